// File: rtl/hvac_seq_pkg.sv
// Shared state codes and default timing constants for the HVAC relay sequencer.
// Optional build macro used by the sequencer: HVAC_SEQ_MAXRUN_EN.
package hvac_seq_pkg;

  localparam int HVAC_STATE_W = 3;

  typedef enum logic [HVAC_STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_HEAT     = 3'd1,
    ST_COOL     = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_SHUTDOWN = 3'd4
  } hvac_state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_MIN_ON  = 4;
  localparam int DEF_MIN_OFF = 3;
  localparam int DEF_MAX_RUN = 10;

  function automatic logic is_run_state(input logic [HVAC_STATE_W-1:0] s);
    return (s == ST_HEAT) || (s == ST_COOL);
  endfunction

endpackage

// File: rtl/hvac_sequencer_if.sv
// Request/relay bundle between the home-control side (master) and the sequencer (slave).
interface hvac_sequencer_if;
  import hvac_seq_pkg::*;

  logic                    tick;
  logic                    heat_req;
  logic                    cool_req;
  logic                    alarm;
  logic                    heater_en;
  logic                    cooler_en;
  logic [HVAC_STATE_W-1:0] status;
  logic                    run_limit;

  modport master (
    output tick, heat_req, cool_req, alarm,
    input  heater_en, cooler_en, status, run_limit
  );

  modport slave (
    input  tick, heat_req, cool_req, alarm,
    output heater_en, cooler_en, status, run_limit
  );

endinterface

// File: rtl/hvac_tick_cnt.sv
// Saturating time-base tick counter; a clear always wins over an increment.
module hvac_tick_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hvac_sequencer.sv
// Heater/cooler relay sequencer: mutual exclusion, min-on / lockout timing, fire-alarm shutdown.
// Build macro HVAC_SEQ_MAXRUN_EN adds a maximum continuous run limit with a run_limit pulse.
module hvac_sequencer
  import hvac_seq_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input logic             Clk,
  input logic             Rst,
  hvac_sequencer_if.slave bus
);

  localparam logic [HVAC_STATE_W-1:0] S_IDLE     = ST_IDLE;
  localparam logic [HVAC_STATE_W-1:0] S_HEAT     = ST_HEAT;
  localparam logic [HVAC_STATE_W-1:0] S_COOL     = ST_COOL;
  localparam logic [HVAC_STATE_W-1:0] S_LOCKOUT  = ST_LOCKOUT;
  localparam logic [HVAC_STATE_W-1:0] S_SHUTDOWN = ST_SHUTDOWN;

  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);

  logic [HVAC_STATE_W-1:0] state;
  logic [HVAC_STATE_W-1:0] state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    min_on_met;
  logic                    min_off_met;
  logic                    state_change;

`ifdef HVAC_SEQ_MAXRUN_EN
  logic max_run_hit;
  logic cap_hit;
  logic run_limit_q;

  assign max_run_hit = (cnt >= MAX_RUN_C);
`else
  logic unused_max_run;

  assign unused_max_run = ^MAX_RUN_C;
`endif

  assign min_on_met   = (cnt >= MIN_ON_C);
  assign min_off_met  = (cnt >= MIN_OFF_C);
  assign state_change = (state_next != state);

  // Counter restarts on every state change, so cnt always measures time spent in the current state.
  hvac_tick_cnt #(
    .CNT_W (CNT_W)
  ) u_tick_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .clr (state_change),
    .inc (bus.tick),
    .cnt (cnt)
  );

  // Alarm preempts everything; a running relay only reaches the other mode via LOCKOUT and IDLE.
  always_comb begin
    state_next = state;
`ifdef HVAC_SEQ_MAXRUN_EN
    cap_hit = 1'b0;
`endif
    if (bus.alarm) begin
      state_next = S_SHUTDOWN;
    end else begin
      case (state)
        S_SHUTDOWN: state_next = S_LOCKOUT;
        S_LOCKOUT: begin
          if (min_off_met) state_next = S_IDLE;
        end
        S_IDLE: begin
          if (bus.heat_req && !bus.cool_req) begin
            state_next = S_HEAT;
          end else if (bus.cool_req && !bus.heat_req) begin
            state_next = S_COOL;
          end
        end
        S_HEAT: begin
          if (!bus.heat_req && min_on_met) begin
            state_next = S_LOCKOUT;
`ifdef HVAC_SEQ_MAXRUN_EN
          end else if (max_run_hit) begin
            state_next = S_LOCKOUT;
            cap_hit    = 1'b1;
`endif
          end
        end
        S_COOL: begin
          if (!bus.cool_req && min_on_met) begin
            state_next = S_LOCKOUT;
`ifdef HVAC_SEQ_MAXRUN_EN
          end else if (max_run_hit) begin
            state_next = S_LOCKOUT;
            cap_hit    = 1'b1;
`endif
          end
        end
        default: state_next = S_LOCKOUT;
      endcase
    end
  end

  // Reset lands in LOCKOUT so power-up and mid-run resets both serve a full compressor lockout.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_LOCKOUT;
    end else begin
      state <= state_next;
    end
  end

`ifdef HVAC_SEQ_MAXRUN_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      run_limit_q <= 1'b0;
    end else begin
      run_limit_q <= cap_hit;
    end
  end

  assign bus.run_limit = run_limit_q && !is_run_state(state) && (state == S_LOCKOUT);
`else
  assign bus.run_limit = 1'b0;
`endif

  assign bus.heater_en = (state == S_HEAT);
  assign bus.cooler_en = (state == S_COOL);
  assign bus.status    = state;

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Sequencing controller between the home-control FSM and the heater/cooler power relays. Takes raw `heat_req`/`cool_req` from the controller, applies mutual exclusion, minimum-on and minimum-off (compressor lockout) times counted in slow time-base ticks, and forces a shutdown while the fire alarm is active. Drives the relay enables and a 3-bit status code for the display path.

## Interface
Parameters:
- `CNT_W`, 8: tick counter width; every timing parameter below must be < 2^CNT_W.
- `MIN_ON`, 4: minimum ticks a relay stays on once energised.
- `MIN_OFF`, 3: lockout ticks with both relays off after any switch-off; this is also the heat/cool dead-time.
- `MAX_RUN`, 10: maximum continuous run ticks; used only with `HVAC_SEQ_MAXRUN_EN`.

Ports:
- `Clk` in 1: clock, rising edge.
- `Rst` in 1: reset. Synchronous, active-high.
- `tick` in 1: one-cycle time-base enable (nominally 1 Hz).
- `heat_req` in 1: heat request from the controller.
- `cool_req` in 1: cool request from the controller.
- `alarm` in 1: fire alarm (SFA); has highest priority.
- `heater_en` out 1: heater relay enable.
- `cooler_en` out 1: cooler relay enable.
- `status` out 3: current state code.
- `run_limit` out 1: one-cycle pulse when the max-run limit forces a stop.

## Operation
- Moore FSM with registered state. Outputs decode from the state register only.
- State codes:
  - IDLE=0
  - HEAT=1: `heater_en`=1
  - COOL=2: `cooler_en`=1
  - LOCKOUT=3
  - SHUTDOWN=4
- `heater_en` and `cooler_en` are never high in the same cycle.
- Tick counter `cnt`:
  - Cleared on every edge that changes state.
  - Otherwise increments on edges where `tick`=1.
  - Saturates at 2^CNT_W−1.
  - A tick coinciding with a state-change edge is not counted.
- Transitions. Priority is top-down within each state:
  - Any state, `alarm`=1 → SHUTDOWN.
  - SHUTDOWN, `alarm`=0 → LOCKOUT.
  - LOCKOUT, `cnt` ≥ MIN_OFF → IDLE.
  - IDLE, `heat_req` & !`cool_req` → HEAT.
  - IDLE, `cool_req` & !`heat_req` → COOL.
  - IDLE, both or neither request → stay IDLE. Conflicting requests are ignored.
  - HEAT, !`heat_req` & `cnt` ≥ MIN_ON → LOCKOUT. COOL uses `cool_req` in the same way.
  - A request for the opposite mode while running has no effect until the current request drops. The path to the other mode is always HEAT → LOCKOUT → IDLE → COOL.
- `alarm` overrides MIN_ON: the relay drops on the next edge regardless of `cnt`.
- Reset: state=LOCKOUT, `cnt`=0, `heater_en`=`cooler_en`=`run_limit`=0, `status`=3. Power-up always serves a full lockout.
- Reset asserted mid-run behaves identically: the relay drops after the reset edge.

## Timing
- Request to relay latency:
  - From IDLE: request sampled at edge N, enable high after edge N.
  - From LOCKOUT: the lockout must first expire, then one IDLE cycle, then the run state.
- Release latency: the first edge where the request is low and `cnt` ≥ MIN_ON; the enable is low after that edge.
- Minimum relay-off gap: MIN_OFF ticks plus 2 cycles (exit cycle + IDLE).
- MIN_ON=0 or MIN_OFF=0 is legal: that condition is satisfied immediately and the state is left on the next edge.
- `tick` held high continuously counts one per cycle.

## Configuration
- Macro `HVAC_SEQ_MAXRUN_EN`.
- Defined:
  - In HEAT/COOL, `cnt` ≥ MAX_RUN forces LOCKOUT even with the request still high.
  - `run_limit` pulses for 1 cycle, the cycle after that edge.
  - `alarm` still has priority; the alarm path does not pulse `run_limit`.
  - After lockout, a still-asserted request re-enters the run state normally.
- Not defined: no run limit; `run_limit` is tied to 0; MAX_RUN is unused.

## Structure
- Package `hvac_seq_pkg`:
  - state enum `hvac_state_t` with the codes above;
  - `HVAC_STATE_W`=3;
  - default timing constants.
- Sub-module `hvac_tick_cnt`: saturating counter with `clr` and `inc` inputs and a CNT_W-bit output. The FSM stays in `hvac_sequencer`.

## Test plan
Defaults apply and `tick`=1 every cycle unless stated.
- Power-up to heat: reset, then `heat_req`=1 held → `status` 3 for 4 edges, IDLE for 1, `heater_en`=1 after the 5th edge; `cooler_en` stays 0.
- Min-on hold: from HEAT entry, drop `heat_req` after 1 cycle → `heater_en` stays 1 until `cnt`=4, then `status`=3 for 3 ticks, then IDLE.
- Mode switch: in HEAT, drop `heat_req` and raise `cool_req` → `heater_en` falls, gap ≥ 5 cycles, then `cooler_en` rises; the enables never overlap.
- Alarm: in HEAT with `cnt`=1, `alarm`=1 → `heater_en`=0 and `status`=4 after the next edge; requests are ignored while alarm is high; drop `alarm` → `status`=3, a full lockout, then IDLE.
- Conflict and gated tick: `heat_req`=`cool_req`=1 in IDLE → stays IDLE for 20 cycles. With `tick` every 4th cycle, lockout lasts 12 cycles ±3.
- Max-run:
  - Macro defined: `heat_req` held → forced LOCKOUT at `cnt`=10, `run_limit` pulses once, HEAT re-entered after the lockout.
  - Macro undefined: HEAT persists and `run_limit`=0.
